// File: rtl/getmax_window_ci.sv
// Windowed max/argmax custom instruction over the last DEPTH pushed samples.
// Optional: define GETMAX_CI_MIN_EN to let dataa[0] select min/argmin at issue.
module getmax_window_ci #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_PUSH   = 2'd1;
    localparam logic [1:0] OP_ARGMAX = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   scan_idx_reg, scan_idx_next;
    logic [DATA_W-1:0]  best_reg, best_next;
    logic [CNT_W-1:0]   best_idx_reg, best_idx_next;
    logic               argmax_reg, argmax_next;
    logic               done_reg, done_next;
    logic [31:0]        result_reg, result_next;

    logic [DATA_W-1:0]  buf_mem [DEPTH];
    logic [DATA_W-1:0]  rd_data_reg;
    logic [PTR_W-1:0]   oldest;
    logic [PTR_W-1:0]   rd_addr;
    logic               wr_en;
    logic               use_min;
    logic               take;
    logic [DATA_W-1:0]  cur_best;
    logic [CNT_W-1:0]   cur_idx;
    logic [31:0]        best_ext;
    logic               unused_dataa;

    assign unused_dataa = ^dataa;
    assign done   = done_reg;
    assign result = result_reg;

`ifdef GETMAX_CI_MIN_EN
    logic min_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            min_reg <= 1'b0;
        end else if (clk_en && state_reg == S_IDLE && start) begin
            min_reg <= dataa[0];
        end
    end
    assign use_min = min_reg;
`else
    assign use_min = 1'b0;
`endif

    // Read address runs one entry ahead so the registered read lines up with scan_idx.
    assign oldest  = wr_ptr_reg - count_reg[PTR_W-1:0];
    assign rd_addr = (state_reg == S_IDLE) ? oldest : rd_ptr_reg + PTR_ONE;

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (wr_en) begin
                buf_mem[wr_ptr_reg] <= dataa[DATA_W-1:0];
            end
            rd_data_reg <= buf_mem[rd_addr];
        end
    end

    // First entry always wins; later ones only on a strict improvement, so ties keep the oldest.
    always_comb begin
        logic gt;
        logic lt;
        if (SIGNED != 0) begin
            gt = $signed(rd_data_reg) > $signed(best_reg);
            lt = $signed(rd_data_reg) < $signed(best_reg);
        end else begin
            gt = rd_data_reg > best_reg;
            lt = rd_data_reg < best_reg;
        end
        take     = (scan_idx_reg == '0) || (use_min ? lt : gt);
        cur_best = take ? rd_data_reg : best_reg;
        cur_idx  = take ? scan_idx_reg : best_idx_reg;
        best_ext = {32{(SIGNED != 0) && cur_best[DATA_W-1]}};
        best_ext[DATA_W-1:0] = cur_best;
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_addr;
        scan_idx_next = scan_idx_reg;
        best_next     = best_reg;
        best_idx_next = best_idx_reg;
        argmax_next   = argmax_reg;
        done_next     = 1'b0;
        result_next   = result_reg;
        wr_en         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    argmax_next = (n == OP_ARGMAX);
                    if (n == OP_CLEAR) begin
                        count_next  = '0;
                        wr_ptr_next = '0;
                        result_next = '0;
                        done_next   = 1'b1;
                    end else if (n == OP_PUSH) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PTR_ONE;
                        count_next  = (count_reg == CNT_FULL) ? count_reg : count_reg + CNT_ONE;
                        result_next = {{(32-CNT_W){1'b0}}, count_next};
                        done_next   = 1'b1;
                    end else if (count_reg == '0) begin
                        result_next = '0;
                        done_next   = 1'b1;
                    end else begin
                        scan_idx_next = '0;
                        state_next    = (count_reg == CNT_ONE) ? S_FINISH : S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                best_next     = cur_best;
                best_idx_next = cur_idx;
                scan_idx_next = scan_idx_reg + CNT_ONE;
                if (scan_idx_reg == count_reg - CNT_TWO) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                // The newest entry is folded in here, straight into the result.
                result_next = argmax_reg ? {{(32-CNT_W){1'b0}}, cur_idx} : best_ext;
                done_next   = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            scan_idx_reg <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
            argmax_reg   <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else if (clk_en) begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            scan_idx_reg <= scan_idx_next;
            best_reg     <= best_next;
            best_idx_reg <= best_idx_next;
            argmax_reg   <= argmax_next;
            done_reg     <= done_next;
            result_reg   <= result_next;
        end
    end
endmodule

// File: tb/tb_getmax_window_ci.sv
// Bench for getmax_window_ci: two configurations driven in lockstep against a queue-based window model.
module tb_getmax_window_ci;
    localparam int W0 = 32, D0 = 16, S0 = 0;
    localparam int W1 = 8,  D1 = 4,  S1 = 1;

    logic        clk, reset, clk_en, start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done0, done1;
    logic [31:0] result0, result1;

    int checks = 0;
    int errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    getmax_window_ci #(.DATA_W(W0), .DEPTH(D0), .SIGNED(S0)) dut0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .done(done0), .result(result0));

    getmax_window_ci #(.DATA_W(W1), .DEPTH(D1), .SIGNED(S1)) dut1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .done(done1), .result(result1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint as_val(input logic [31:0] x, input int w, input bit sgn);
        longint v;
        v = longint'(x);
        if (sgn && x[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic logic [31:0] ref_scan(input logic [31:0] q[$], input int w, input bit sgn,
                                             input bit want_min, input bit arg);
        longint best, v;
        int bi;
        if (q.size() == 0) return 32'h0;
        best = as_val(q[0], w, sgn);
        bi = 0;
        for (int i = 1; i < q.size(); i++) begin
            v = as_val(q[i], w, sgn);
            if (want_min ? (v < best) : (v > best)) begin
                best = v;
                bi = i;
            end
        end
        return arg ? 32'(bi) : best[31:0];
    endfunction

    // Issue one instruction, let clk_en drop for stall_len cycles after stall_at, then check both DUTs.
    task automatic run_op(input string p, input logic [1:0] op, input logic [31:0] d,
                          input int stall_at, input int stall_len);
        logic [31:0] er0, er1, r0, r1;
        int el0, el1, l0, l1, lim, cyc;
        bit wmin;
        wmin = 1'b0;
`ifdef GETMAX_CI_MIN_EN
        wmin = d[0];
`endif
        case (op)
            2'd0: begin
                q0.delete(); q1.delete();
                er0 = 0; er1 = 0; el0 = 1; el1 = 1;
            end
            2'd1: begin
                q0.push_back(d);
                if (q0.size() > D0) void'(q0.pop_front());
                q1.push_back({24'h0, d[7:0]});
                if (q1.size() > D1) void'(q1.pop_front());
                er0 = 32'(q0.size()); er1 = 32'(q1.size()); el0 = 1; el1 = 1;
            end
            default: begin
                er0 = ref_scan(q0, W0, S0 != 0, wmin, op == 2'd3);
                er1 = ref_scan(q1, W1, S1 != 0, wmin, op == 2'd3);
                el0 = (q0.size() == 0) ? 1 : 1 + q0.size();
                el1 = (q1.size() == 0) ? 1 : 1 + q1.size();
            end
        endcase
        if (stall_len > 0 && stall_at < el0) el0 += stall_len;
        if (stall_len > 0 && stall_at < el1) el1 += stall_len;
        lim = (el0 > el1) ? el0 : el1;
        start = 1'b1; n = op; dataa = d; clk_en = 1'b1;
        l0 = -1; l1 = -1; r0 = '0; r1 = '0; cyc = 0;
        while (cyc < lim) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done0 && l0 < 0) begin l0 = cyc; r0 = result0; end
            if (done1 && l1 < 0) begin l1 = cyc; r1 = result1; end
            clk_en = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : 1'b1;
        end
        clk_en = 1'b1;
        check({p, " lat0"}, 32'(l0), 32'(el0));
        check({p, " res0"}, r0, er0);
        check({p, " lat1"}, 32'(l1), 32'(el1));
        check({p, " res1"}, r1, er1);
        @(posedge clk); #1;
        check({p, " pulse"}, {30'h0, done1, done0}, 32'h0);
        check({p, " hold0"}, result0, er0);
        $display("op %s n=%0d dataa=0x%08h res0=0x%08h res1=0x%08h lat0=%0d lat1=%0d",
                 p, op, d, r0, r1, l0, l1);
    endtask

    initial begin
        int any_done;
        logic [1:0] op;
        logic [31:0] d;
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset done", {30'h0, done1, done0}, 32'h0);
        check("reset result0", result0, 32'h0);
        check("reset result1", result1, 32'h0);

        run_op("max_empty", 2'd2, 32'h0, 0, 0);
        run_op("push5", 2'd1, 32'd5, 0, 0);
        run_op("push9", 2'd1, 32'd9, 0, 0);
        run_op("push3", 2'd1, 32'd3, 0, 0);
        run_op("push9b", 2'd1, 32'd9, 0, 0);
        run_op("max4", 2'd2, 32'h0, 0, 0);
        run_op("argmax4", 2'd3, 32'h0, 0, 0);

        run_op("clear", 2'd0, 32'h0, 0, 0);
        run_op("push100", 2'd1, 32'd100, 0, 0);
        run_op("push1", 2'd1, 32'd1, 0, 0);
        run_op("push2", 2'd1, 32'd2, 0, 0);
        run_op("push3", 2'd1, 32'd3, 0, 0);
        run_op("push4_evict", 2'd1, 32'd4, 0, 0);
        run_op("max_evict", 2'd2, 32'h0, 0, 0);
        run_op("argmax_evict", 2'd3, 32'h0, 0, 0);

        run_op("clear2", 2'd0, 32'h0, 0, 0);
        run_op("push80", 2'd1, 32'h80, 0, 0);
        run_op("push7f", 2'd1, 32'h7F, 0, 0);
        run_op("pushff", 2'd1, 32'hFF, 0, 0);
        run_op("max_sign", 2'd2, 32'h0, 0, 0);
        run_op("max_stall", 2'd2, 32'h0, 2, 2);

        // Reset (with clk_en low) lands while both DUTs are mid-scan.
        start = 1'b1; n = 2'd2; dataa = '0; clk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; clk_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; clk_en = 1'b1;
        q0.delete(); q1.delete();
        check("abort result0", result0, 32'h0);
        check("abort result1", result1, 32'h0);
        any_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done0 || done1) any_done++;
            @(posedge clk); #1;
        end
        check("abort no_done", 32'(any_done), 32'h0);
        $display("op abort_reset done_cycles=%0d", any_done);
        run_op("max_after_abort", 2'd2, 32'h0, 0, 0);

`ifdef GETMAX_CI_MIN_EN
        run_op("pushm7", 2'd1, 32'd7, 0, 0);
        run_op("pushm2", 2'd1, 32'd2, 0, 0);
        run_op("pushm2b", 2'd1, 32'd2, 0, 0);
        run_op("pushm8", 2'd1, 32'd8, 0, 0);
        run_op("min", 2'd2, 32'h1, 0, 0);
        run_op("argmin", 2'd3, 32'h1, 0, 0);
        run_op("max_mode0", 2'd2, 32'h0, 0, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) op = 2'd0;
            else if (sel < 12) op = 2'd1;
            else if (sel < 16) op = 2'd2;
            else op = 2'd3;
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) == 0)
                run_op($sformatf("rnd%0d", i), op, d, $urandom_range(1, 3), $urandom_range(1, 2));
            else
                run_op($sformatf("rnd%0d", i), op, d, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
